ddr4_phy_riu_access_ctrl: RTL and testbench
===========================================

Name: ddr4_phy_riu_access_ctrl

Overview:
- RIU initiator for XIPHY nibbles: single-outstanding register read/write engine on the RIU clock.
- Converts request/response handshakes from calibration/debug logic into RIU address, write-data, write-enable and one-hot nibble-select cycles.
- Collects the ORed per-byte read data and valid returned by the RIU OR tree, applying a timeout.
- Sits between the calibration MicroBlaze/debug bridge and the XIPHY byte-lane RIU ports.

Parameters:
- NUM_NIBBLES, 8, number of addressable nibbles (nibble-select width)
- ADDR_W, 6, RIU register address width
- DATA_W, 16, RIU data width
- TIMEOUT_CYCLES, 64, read-wait cycles before error completion (min 2)

Ports:
- riu_clk  input  1  RIU clock
- rst  input  1  reset
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when high with req_valid
- req_write  input  1  1=write, 0=read
- req_nibble  input  8  nibble index
- req_addr  input  ADDR_W  register address
- req_wdata  input  DATA_W  write data
- resp_valid  output  1  response valid
- resp_ready  input  1  response consumed
- resp_rdata  output  DATA_W  read data (0 for writes/errors)
- resp_err  output  1  timeout or illegal nibble
- riu_addr  output  ADDR_W  RIU address
- riu_wr_data  output  DATA_W  RIU write data
- riu_wr_en  output  1  RIU write strobe
- riu_nibble_sel  output  NUM_NIBBLES  one-hot nibble select
- riu_rd_data  input  DATA_W  ORed RIU read data
- riu_valid  input  1  ORed RIU read valid

Behaviour:
- Interface: one clock `riu_clk`; reset `rst` is asynchronous and active-high.
- Reset: all outputs and state go to 0/IDLE; req_ready=0 while rst is asserted and 1 in IDLE thereafter.
- All RIU outputs are registered. riu_nibble_sel and riu_wr_en are 0 outside ISSUE cycles. riu_addr/riu_wr_data hold their last values.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch the request.
  - req_nibble >= NUM_NIBBLES -> RESP with err=1, rdata=0; no RIU activity.
  - Otherwise write -> WR; read -> RD_ISSUE.
- WR: one cycle with riu_wr_en=1, nibble_sel one-hot, addr/wdata driven -> RESP, err=0.
- RD_ISSUE: one cycle with nibble_sel one-hot, riu_wr_en=0, addr driven. Clear the timeout counter -> RD_WAIT.
- RD_WAIT:
  - riu_valid=1 -> capture riu_rd_data into resp_rdata -> RESP, err=0.
  - Else increment the counter; at TIMEOUT_CYCLES-1 -> RESP, err=1, rdata=0.
  - riu_valid in the same cycle as the timeout wins, with err=0.
- RESP: resp_valid=1 with stable rdata/err until resp_ready=1, then IDLE. A new request can be accepted no earlier than the cycle after the handshake.
- Latency, with request accepted at cycle N:
  - Write: riu_wr_en at N+1, resp_valid at N+2.
  - Read: sel at N+1; riu_valid at cycle M>=N+2 gives resp_valid at M+1.
- riu_valid outside RD_WAIT is ignored and does not corrupt rdata.
- Asynchronous reset mid-access: immediate IDLE, strobes drop, and the pending response is discarded.

Optional Feature:
- Macro: RIU_ACCESS_BCAST_EN.
- Defined: req_nibble=8'hFF on a write asserts all riu_nibble_sel bits in WR (broadcast). On a read it completes as an error with no RIU activity.
- Undefined: 8'hFF is an illegal index like any other value >= NUM_NIBBLES.

Decomposition:
- Shared package ddr4_phy_riu_pkg holds:
  - the FSM state enum
  - RIU_BCAST_NIBBLE constant (8'hFF)
  - default width constants
- One natural sub-module: ddr4_phy_riu_nibble_dec, an index-to-one-hot decoder with out-of-range and broadcast flags.

Test Plan:
- Write nibble 3, addr 6'h12, data 16'hA5A5 -> at N+1 riu_wr_en=1, sel=8'h08, addr=12, wdata=A5A5; resp_valid at N+2, err=0.
- Read nibble 0, riu_valid with 16'h1234 three cycles after sel -> resp_rdata=1234, err=0; resp held 4 cycles with resp_ready=0.
- Read, no riu_valid -> resp_err=1, rdata=0 exactly TIMEOUT_CYCLES cycles after RD_WAIT entry; riu_valid on the final cycle gives err=0.
- req_nibble=9 -> resp err=1 at N+1, sel never asserted; with RIU_ACCESS_BCAST_EN, write to 8'hFF gives sel=8'hFF.
- Stray riu_valid in IDLE/WR, then rst asserted mid RD_WAIT -> outputs 0 asynchronously, state IDLE, no resp_valid, next read completes normally.

Source files
------------

// File: rtl/ddr4_phy_riu_pkg.sv
// rtl/ddr4_phy_riu_pkg.sv - shared types and defaults for the RIU access controller
package ddr4_phy_riu_pkg;

  localparam int RIU_NUM_NIBBLES    = 8;
  localparam int RIU_ADDR_W         = 6;
  localparam int RIU_DATA_W         = 16;
  localparam int RIU_TIMEOUT_CYCLES = 64;

  localparam logic [7:0] RIU_BCAST_NIBBLE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RESP     = 3'd4
  } riu_state_e;

endpackage

// File: rtl/ddr4_phy_riu_nibble_dec.sv
// rtl/ddr4_phy_riu_nibble_dec.sv - nibble index to one-hot select with range/broadcast flags
// Broadcast index recognised only when RIU_ACCESS_BCAST_EN is defined.
module ddr4_phy_riu_nibble_dec
  import ddr4_phy_riu_pkg::*;
#(
  parameter int NUM_NIBBLES = RIU_NUM_NIBBLES
) (
  input  logic [7:0]             nibble,
  output logic [NUM_NIBBLES-1:0] sel,
  output logic                   out_of_range,
  output logic                   bcast
);

  always_comb begin
`ifdef RIU_ACCESS_BCAST_EN
    bcast = (nibble == RIU_BCAST_NIBBLE);
`else
    bcast = 1'b0;
`endif
    out_of_range = (32'(nibble) >= NUM_NIBBLES);
    sel = '0;
    for (int i = 0; i < NUM_NIBBLES; i++) begin
      sel[i] = bcast || (32'(nibble) == i);
    end
  end

endmodule

// File: rtl/ddr4_phy_riu_access_ctrl.sv
// rtl/ddr4_phy_riu_access_ctrl.sv - single-outstanding RIU register read/write initiator
// Optional write broadcast to all nibbles via RIU_ACCESS_BCAST_EN.
module ddr4_phy_riu_access_ctrl
  import ddr4_phy_riu_pkg::*;
#(
  parameter int NUM_NIBBLES    = RIU_NUM_NIBBLES,
  parameter int ADDR_W         = RIU_ADDR_W,
  parameter int DATA_W         = RIU_DATA_W,
  parameter int TIMEOUT_CYCLES = RIU_TIMEOUT_CYCLES
) (
  input  logic                   riu_clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [7:0]             req_nibble,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic                   resp_err,
  output logic [ADDR_W-1:0]      riu_addr,
  output logic [DATA_W-1:0]      riu_wr_data,
  output logic                   riu_wr_en,
  output logic [NUM_NIBBLES-1:0] riu_nibble_sel,
  input  logic [DATA_W-1:0]      riu_rd_data,
  input  logic                   riu_valid
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  riu_state_e state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_d;
  logic [DATA_W-1:0]      wdata_d, rdata_d;
  logic                   wr_en_d, err_d;
  logic [NUM_NIBBLES-1:0] sel_d, dec_sel;
  logic                   dec_oor, dec_bcast, illegal;

  ddr4_phy_riu_nibble_dec #(.NUM_NIBBLES(NUM_NIBBLES)) u_dec (
    .nibble       (req_nibble),
    .sel          (dec_sel),
    .out_of_range (dec_oor),
    .bcast        (dec_bcast)
  );

  // Broadcast is only meaningful for writes; a broadcast read is an error.
  assign illegal    = dec_oor && !(dec_bcast && req_write);
  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign resp_valid = (state_q == ST_RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = riu_addr;
    wdata_d = riu_wr_data;
    rdata_d = resp_rdata;
    err_d   = resp_err;
    wr_en_d = 1'b0;
    sel_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rdata_d = '0;
          err_d   = 1'b0;
          if (illegal) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            addr_d = req_addr;
            sel_d  = dec_sel;
            if (req_write) begin
              wr_en_d = 1'b1;
              wdata_d = req_wdata;
              state_d = ST_WR;
            end else begin
              state_d = ST_RD_ISSUE;
            end
          end
        end
      end
      ST_WR:       state_d = ST_RESP;
      ST_RD_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // Returned data takes priority over a timeout in the same cycle.
        if (riu_valid) begin
          rdata_d = riu_rd_data;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge riu_clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      riu_addr       <= '0;
      riu_wr_data    <= '0;
      riu_wr_en      <= 1'b0;
      riu_nibble_sel <= '0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      riu_addr       <= addr_d;
      riu_wr_data    <= wdata_d;
      riu_wr_en      <= wr_en_d;
      riu_nibble_sel <= sel_d;
      resp_rdata     <= rdata_d;
      resp_err       <= err_d;
    end
  end

endmodule

// File: tb/tb_ddr4_phy_riu_access_ctrl.sv
// tb/tb_ddr4_phy_riu_access_ctrl.sv - self-checking bench for ddr4_phy_riu_access_ctrl
module tb_ddr4_phy_riu_access_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_nibble;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [15:0] resp_rdata;
  logic [5:0]  riu_addr;
  logic [15:0] riu_wr_data, riu_rd_data;
  logic        riu_wr_en, riu_valid;
  logic [7:0]  riu_nibble_sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ddr4_phy_riu_access_ctrl #(
    .NUM_NIBBLES(8), .ADDR_W(6), .DATA_W(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .riu_clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_nibble(req_nibble), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .riu_addr(riu_addr), .riu_wr_data(riu_wr_data), .riu_wr_en(riu_wr_en),
    .riu_nibble_sel(riu_nibble_sel), .riu_rd_data(riu_rd_data), .riu_valid(riu_valid)
  );

  typedef struct {
    bit          wr;
    logic [7:0]  nib;
    logic [5:0]  addr;
    logic [15:0] wdata;
    int          d;      // riu_valid this many cycles after the select cycle (0 = never)
    logic [15:0] rin;
    int          hold;
    bit          stray;
    int          e_lat;  // cycles from accept to first resp_valid
    bit          e_err;
    logic [15:0] e_rdata;
    logic [7:0]  e_sel;
    bit          e_wr;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [7:0] nib, logic [5:0] addr, logic [15:0] wdata,
                              int d, logic [15:0] rin, int hold, bit stray,
                              int e_lat, bit e_err, logic [15:0] e_rdata, logic [7:0] e_sel, bit e_wr);
    vec_t v;
    v.wr = wr; v.nib = nib; v.addr = addr; v.wdata = wdata; v.d = d; v.rin = rin;
    v.hold = hold; v.stray = stray; v.e_lat = e_lat; v.e_err = e_err;
    v.e_rdata = e_rdata; v.e_sel = e_sel; v.e_wr = e_wr;
    return v;
  endfunction

  // Reference: outcome of one access derived directly from the access rules.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    bit bc = 1'b0;
`ifdef RIU_ACCESS_BCAST_EN
    bc = v.wr && (v.nib == 8'hFF);
`endif
    r.e_rdata = 16'h0; r.e_err = 1'b0; r.e_wr = 1'b0; r.e_sel = 8'h0;
    if (v.nib >= 8 && !bc) begin
      r.e_lat = 1; r.e_err = 1'b1;
    end else if (v.wr) begin
      r.e_lat = 2; r.e_wr = 1'b1;
      r.e_sel = bc ? 8'hFF : (8'h1 << v.nib);
    end else begin
      r.e_sel = 8'h1 << v.nib;
      if (v.d >= 1 && v.d <= TO) begin
        r.e_lat = v.d + 2; r.e_rdata = v.rin;
      end else begin
        r.e_lat = TO + 2; r.e_err = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic run(input vec_t v);
    logic [7:0]  sel1;
    logic [5:0]  addr1;
    logic [15:0] wd1;
    bit          wr1, extra, stable, pulse;
    int          lat;
    if (v.stray) begin
      riu_valid = 1'b1; riu_rd_data = 16'($urandom);
      @(posedge clk); @(negedge clk);
      riu_valid = 1'b0;
    end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = v.wr; req_nibble = v.nib;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_nibble = 8'($urandom); req_addr = 6'($urandom);
    req_wdata = 16'($urandom); req_write = 1'($urandom);
    lat = -1; extra = 1'b0; sel1 = '0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
    for (int k = 1; k <= TO + 6; k++) begin
      if (k == 1) begin
        sel1 = riu_nibble_sel; wr1 = riu_wr_en; addr1 = riu_addr; wd1 = riu_wr_data;
      end else if (riu_nibble_sel != 8'h0 || riu_wr_en) begin
        extra = 1'b1;
      end
      if (resp_valid) begin
        lat = k;
        break;
      end
      pulse = !v.wr && v.d >= 1 && k == v.d + 1;
      riu_valid = pulse || (v.stray && k == 1);
      riu_rd_data = pulse ? v.rin : 16'($urandom);
      @(posedge clk); @(negedge clk);
    end
    riu_valid = 1'b0;
    chk("resp_latency", 32'(lat), 32'(v.e_lat));
    chk("resp_err", 32'(resp_err), 32'(v.e_err));
    chk("resp_rdata", 32'(resp_rdata), 32'(v.e_rdata));
    chk("issue_sel", 32'(sel1), 32'(v.e_sel));
    chk("issue_wr_en", 32'(wr1), 32'(v.e_wr));
    chk("strobe_outside_issue", 32'(extra), 32'd0);
    if (v.e_sel != 8'h0) chk("issue_addr", 32'(addr1), 32'(v.addr));
    if (v.e_wr) chk("issue_wdata", 32'(wd1), 32'(v.wdata));
    stable = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      if (!resp_valid || resp_rdata !== v.e_rdata || resp_err !== v.e_err) stable = 1'b0;
      riu_valid = 1'b1; riu_rd_data = 16'($urandom);
      @(posedge clk); @(negedge clk);
    end
    riu_valid = 1'b0;
    if (!resp_valid || resp_rdata !== v.e_rdata || resp_err !== v.e_err) stable = 1'b0;
    chk("resp_hold_stable", 32'(stable), 32'd1);
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop_after_handshake", 32'(resp_valid), 32'd0);
  endtask

  vec_t tbl[10];
  vec_t rv;
  bit   seen;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(1, 8'd3,  6'h12, 16'hA5A5, 0, 16'h0,    0, 0, 2,  0, 16'h0,    8'h08, 1);
    tbl[1] = mk(0, 8'd0,  6'h05, 16'h0,    3, 16'h1234, 4, 0, 5,  0, 16'h1234, 8'h01, 0);
    tbl[2] = mk(0, 8'd7,  6'h3F, 16'h0,    0, 16'h0,    1, 0, 10, 1, 16'h0,    8'h80, 0);
    tbl[3] = mk(0, 8'd2,  6'h01, 16'h0,    8, 16'hBEEF, 0, 0, 10, 0, 16'hBEEF, 8'h04, 0);
    tbl[4] = mk(0, 8'd5,  6'h20, 16'h0,    1, 16'h0F0F, 2, 1, 3,  0, 16'h0F0F, 8'h20, 0);
    tbl[5] = mk(1, 8'd9,  6'h0A, 16'hFFFF, 0, 16'h0,    0, 0, 1,  1, 16'h0,    8'h00, 0);
    tbl[6] = mk(0, 8'hFF, 6'h00, 16'h0,    2, 16'h1111, 0, 0, 1,  1, 16'h0,    8'h00, 0);
`ifdef RIU_ACCESS_BCAST_EN
    tbl[7] = mk(1, 8'hFF, 6'h2A, 16'hC3C3, 0, 16'h0,    0, 0, 2,  0, 16'h0,    8'hFF, 1);
`else
    tbl[7] = mk(1, 8'hFF, 6'h2A, 16'hC3C3, 0, 16'h0,    0, 0, 1,  1, 16'h0,    8'h00, 0);
`endif
    tbl[8] = mk(0, 8'd1,  6'h11, 16'h0,    9, 16'h2222, 0, 0, 10, 1, 16'h0,    8'h02, 0);
    tbl[9] = mk(1, 8'd7,  6'h3E, 16'h0001, 0, 16'h0,    1, 1, 2,  0, 16'h0,    8'h80, 1);

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_nibble = '0; req_addr = '0;
    req_wdata = '0; resp_ready = 1'b0; riu_rd_data = '0; riu_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_riu_outputs", {riu_addr, riu_wr_data, riu_wr_en, riu_nibble_sel}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run(tbl[i]);

    // Asynchronous reset while waiting for read data.
    req_valid = 1'b1; req_write = 1'b0; req_nibble = 8'd4; req_addr = 6'h33;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_no_resp", 32'(resp_valid), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req_ready", 32'(req_ready), 32'd0);
    chk("async_rst_outputs", {riu_addr, riu_wr_en, riu_nibble_sel, resp_valid, resp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      #1 if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("no_resp_after_rst", 32'(seen), 32'd0);
    run(mk(0, 8'd4, 6'h33, 16'h0, 2, 16'h5A5A, 1, 1, 4, 0, 16'h5A5A, 8'h10, 0));

    for (int i = 0; i < 40; i++) begin
      rv.wr    = 1'($urandom);
      rv.nib   = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 11));
      rv.addr  = 6'($urandom);
      rv.wdata = 16'($urandom);
      rv.d     = $urandom_range(0, TO + 2);
      rv.rin   = 16'($urandom);
      rv.hold  = $urandom_range(0, 3);
      rv.stray = 1'($urandom);
      run(model(rv));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
